// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample feeder: default sample width,
// feeder state encoding and underrun counter sizing.
package audio_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    localparam int                UCNT_W   = 8;
    localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for stereo pairs. Push/pop requests are qualified
// internally against full/empty, and flush empties it in one cycle.
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Sample storage, no reset needed: contents are only read when count says valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/audio_sample_feeder.sv
// Buffers producer stereo pairs and hands one pair to the DAC at the start
// of every left half-frame, with prefill gating and underrun tracking.
module audio_sample_feeder
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 16,
    parameter int PREFILL    = 8
) (
    input  logic                   CLK_18_4,
    input  logic                   RST,
    input  logic                   enable,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_left,
    input  logic [DATA_WIDTH-1:0]  in_right,
    input  logic                   AUD_LRCK,
    output logic [DATA_WIDTH-1:0]  left_sample,
    output logic [DATA_WIDTH-1:0]  right_sample,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underrun,
    output logic [UCNT_W-1:0]      underrun_count,
    input  logic                   clear_underrun
);

    localparam int            LW        = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);

    feeder_state_t           state;
    feeder_state_t           state_nxt;
    logic                    lrck_q;
    logic                    strobe;
    logic                    push;
    logic                    pop;
    logic                    urun_evt;
    logic                    fill_done;
    logic                    full;
    logic                    empty;
    logic [2*DATA_WIDTH-1:0] head;

    // Reset gates in_ready so nothing is accepted while the block is held
    assign in_ready  = enable & ~full & ~RST;
    assign push      = in_valid & in_ready;
    assign strobe    = lrck_q & ~AUD_LRCK;
    // Prefill threshold counts the pair being pushed this cycle
    assign fill_done = (level + LW'(push)) >= PREFILL_L;

    sample_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK_18_4),
        .rst     (RST),
        .push    (push),
        .pop     (pop),
        .flush   (~enable),
        .wr_data ({in_left, in_right}),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Previous LRCK; held low in reset so the first edge after release cannot strobe
    always_ff @(posedge CLK_18_4 or posedge RST) begin
        if (RST) lrck_q <= 1'b0;
        else     lrck_q <= AUD_LRCK;
    end

    // State register
    always_ff @(posedge CLK_18_4 or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus pop/underrun decode; disable overrides everything
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        urun_evt  = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_FILL;
                ST_FILL: if (fill_done) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (strobe) begin
                        if (empty) begin
                            urun_evt  = 1'b1;
                            state_nxt = ST_FILL;
                        end else begin
                            pop = 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // DAC sample registers: load on pop, zero on underrun or disable, else hold
    always_ff @(posedge CLK_18_4 or posedge RST) begin
        if (RST) begin
            left_sample  <= '0;
            right_sample <= '0;
        end else if (!enable || urun_evt) begin
            left_sample  <= '0;
            right_sample <= '0;
        end else if (pop) begin
            left_sample  <= head[2*DATA_WIDTH-1:DATA_WIDTH];
            right_sample <= head[DATA_WIDTH-1:0];
        end
    end

    // Sticky underrun flag and saturating counter; a coincident event beats clear
    always_ff @(posedge CLK_18_4 or posedge RST) begin
        if (RST) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (clear_underrun) begin
            underrun       <= urun_evt;
            underrun_count <= urun_evt ? UCNT_W'(1) : '0;
        end else if (urun_evt) begin
            underrun <= 1'b1;
            if (underrun_count != UCNT_MAX) underrun_count <= underrun_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Randomized scoreboard bench for audio_sample_feeder. A queue-based model
// predicts the post-edge outputs for every clock; a monitor compares them.
module tb_audio_sample_feeder;

    localparam int DW      = 16;
    localparam int DEPTH   = 16;
    localparam int PREFILL = 8;
    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_RUN   = 2;

    logic          CLK_18_4 = 1'b0;
    logic          RST;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_left;
    logic [DW-1:0] in_right;
    logic          AUD_LRCK;
    logic [DW-1:0] left_sample;
    logic [DW-1:0] right_sample;
    logic [4:0]    level;
    logic          underrun;
    logic [7:0]    underrun_count;
    logic          clear_underrun;

    audio_sample_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .CLK_18_4       (CLK_18_4),
        .RST            (RST),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_left        (in_left),
        .in_right       (in_right),
        .AUD_LRCK       (AUD_LRCK),
        .left_sample    (left_sample),
        .right_sample   (right_sample),
        .level          (level),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .clear_underrun (clear_underrun)
    );

    always #27 CLK_18_4 = ~CLK_18_4;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            lvl;
        bit            rdy;
        bit            ur;
        int            cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    bit          done     = 1'b0;

    // reference model state
    logic [31:0]   q[$];
    int            mode = M_IDLE;
    bit            lprev = 1'b0;
    logic [DW-1:0] m_l = '0;
    logic [DW-1:0] m_r = '0;
    bit            m_ur = 1'b0;
    int            m_cnt = 0;
    int            total_urun = 0;

    // stimulus generator state
    int lrck_cnt  = 0;
    int drop_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model across the coming clock edge with the inputs now applied
    task automatic step(input bit rst_edge);
        exp_t e;
        bit   strobe;
        bit   pushed;
        bit   ev;
        ev = 1'b0;
        if (rst_edge) begin
            q.delete();
            mode  = M_IDLE;
            lprev = 1'b0;
            m_l   = '0;
            m_r   = '0;
            m_ur  = 1'b0;
            m_cnt = 0;
        end else begin
            strobe = lprev && !AUD_LRCK;
            pushed = in_valid && enable && (q.size() < DEPTH);
            lprev  = AUD_LRCK;
            if (!enable) begin
                q.delete();
                mode = M_IDLE;
                m_l  = '0;
                m_r  = '0;
            end else if (mode == M_IDLE) begin
                mode = M_FILL;
                if (pushed) q.push_back({in_left, in_right});
            end else if (mode == M_FILL) begin
                if (pushed) q.push_back({in_left, in_right});
                if (q.size() >= PREFILL) mode = M_RUN;
            end else begin
                if (strobe) begin
                    if (q.size() > 0) begin
                        {m_l, m_r} = q.pop_front();
                    end else begin
                        m_l  = '0;
                        m_r  = '0;
                        ev   = 1'b1;
                        mode = M_FILL;
                    end
                end
                if (pushed) q.push_back({in_left, in_right});
            end
            if (ev) total_urun++;
            if (clear_underrun) begin
                m_ur  = ev;
                m_cnt = ev ? 1 : 0;
            end else if (ev) begin
                m_ur = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        e.l   = m_l;
        e.r   = m_r;
        e.lvl = q.size();
        e.rdy = !rst_edge && enable && (q.size() < DEPTH);
        e.ur  = m_ur;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Randomize inputs for one cycle
    task automatic gen(input int push_pct, input int half, input int clr_pct,
                       input int drop_pct, input bit force_clr);
        in_valid = ($urandom_range(99) < push_pct);
        in_left  = DW'($urandom);
        in_right = DW'($urandom);
        if (half > 0) begin
            lrck_cnt++;
            if (lrck_cnt >= half) begin
                AUD_LRCK = ~AUD_LRCK;
                lrck_cnt = 0;
            end
        end
        if (drop_left > 0) drop_left--;
        else if ($urandom_range(99) < drop_pct) drop_left = 1 + $urandom_range(2);
        enable = (drop_left == 0);
        clear_underrun = ($urandom_range(99) < clr_pct);
        if (force_clr && enable && mode == M_RUN && lprev && !AUD_LRCK && q.size() == 0)
            clear_underrun = $urandom_range(1) == 1;
    endtask

    task automatic run_phase(input int ncyc, input int push_pct, input int half,
                             input int clr_pct, input int drop_pct, input bit force_clr);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK_18_4);
            gen(push_pct, half, clr_pct, drop_pct, force_clr);
            step(1'b0);
        end
    endtask

    // Monitor: compare DUT outputs against the queued prediction after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK_18_4);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("left_sample",    32'(left_sample),    32'(e.l));
                chk("right_sample",   32'(right_sample),   32'(e.r));
                chk("level",          32'(level),          e.lvl);
                chk("in_ready",       32'(in_ready),       32'(e.rdy));
                chk("underrun",       32'(underrun),       32'(e.ur));
                chk("underrun_count", 32'(underrun_count), e.cnt);
            end else if (!done) begin
                chk("scoreboard_empty", 32'(sb.size()), 32'd1);
            end
        end
    end

    initial begin
        RST = 1'b1;
        enable = 1'b0;
        in_valid = 1'b0;
        in_left = '0;
        in_right = '0;
        AUD_LRCK = 1'b1;
        clear_underrun = 1'b0;
        step(1'b1);
        #5;
        chk("rst_left",     32'(left_sample),    32'd0);
        chk("rst_level",    32'(level),          32'd0);
        chk("rst_in_ready", 32'(in_ready),       32'd0);
        chk("rst_ucount",   32'(underrun_count), 32'd0);

        @(negedge CLK_18_4);
        step(1'b1);
        @(negedge CLK_18_4);
        RST = 1'b0;
        AUD_LRCK = 1'b0;
        enable = 1'b1;
        step(1'b0);

        run_phase(300,  70, 4, 3, 0, 1'b0);   // steady playback
        run_phase(60,   90, 0, 0, 0, 1'b0);   // no frames: FIFO fills to DEPTH
        run_phase(80,    0, 2, 0, 0, 1'b0);   // drain into underruns
        run_phase(1500, 50, 3, 2, 1, 1'b0);   // mixed with enable drops

        // async reset mid-playback
        for (int c = 0; c < 2000 && mode != M_RUN; c++) begin
            @(negedge CLK_18_4);
            gen(60, 3, 0, 0, 1'b0);
            step(1'b0);
        end
        checks++;
        if (mode != M_RUN) begin
            failures++;
            $display("FAIL reach_run: got mode %0d want %0d", mode, M_RUN);
        end
        @(negedge CLK_18_4);
        gen(60, 3, 0, 0, 1'b0);
        AUD_LRCK = 1'b1;
        step(1'b1);
        #10 RST = 1'b1;
        #1;
        chk("async_left",     32'(left_sample),  32'd0);
        chk("async_right",    32'(right_sample), 32'd0);
        chk("async_level",    32'(level),        32'd0);
        chk("async_in_ready", 32'(in_ready),     32'd0);
        @(negedge CLK_18_4);
        AUD_LRCK = 1'b1;
        step(1'b1);
        @(negedge CLK_18_4);
        RST = 1'b0;
        gen(60, 0, 0, 0, 1'b0);
        AUD_LRCK = 1'b0;
        step(1'b0);

        // underrun storm until the counter saturates, then keep going
        total_urun = 0;
        for (int c = 0; c < 60000 && total_urun < 300; c++) begin
            @(negedge CLK_18_4);
            gen(25, 1, 0, 0, 1'b0);
            step(1'b0);
        end
        @(posedge CLK_18_4);
        #5;
        chk("storm_events_reached", 32'(total_urun >= 300), 32'd1);
        chk("ucount_saturated",     32'(underrun_count),    32'd255);

        run_phase(600, 25, 1, 1, 0, 1'b1);   // clears landing on underruns

        @(posedge CLK_18_4);
        #5;
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
